// File: rtl/prescaled_counter_bank.sv
// Bank of N_CH up/down modulo counters advanced by one shared runtime-programmable prescaler.
// Define SNAPSHOT_EN to add the atomic capture register (snap_req / snap_count).
module prescaled_counter_bank #(
  parameter int N_CH       = 2,
  parameter int WIDTH      = 24,
  parameter int PRESCALE_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [PRESCALE_W-1:0]   prescale_limit,
  input  logic [WIDTH-1:0]        wrap_max,
  input  logic [N_CH-1:0]         ch_down,
  input  logic [N_CH-1:0]         ch_load,
  input  logic [WIDTH-1:0]        load_value,
`ifdef SNAPSHOT_EN
  input  logic                    snap_req,
  output logic [N_CH*WIDTH-1:0]   snap_count,
`endif
  output logic [N_CH*WIDTH-1:0]   count,
  output logic                    tick,
  output logic [N_CH-1:0]         wrap
);

  logic [PRESCALE_W-1:0]        pre_r;
  logic                         tick_s;
  logic                         tick_r;
  logic [N_CH-1:0][WIDTH-1:0]   count_r;
  logic [N_CH-1:0][WIDTH-1:0]   count_nxt_s;
  logic [N_CH-1:0]              wrap_r;
  logic [N_CH-1:0]              wrap_nxt_s;

  // '>=' lets a lowered limit fire on the next enabled cycle instead of running the prescaler around.
  assign tick_s = en & (pre_r >= prescale_limit);

  // Prescaler: restarts on every tick, frozen while en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_r <= {PRESCALE_W{1'b0}};
    end else if (en) begin
      if (tick_s) begin
        pre_r <= {PRESCALE_W{1'b0}};
      end else begin
        pre_r <= pre_r + PRESCALE_W'(1);
      end
    end else begin
      pre_r <= pre_r;
    end
  end

  // Per-channel next count and wrap flag; a load always beats the tick.
  always_comb begin
    count_nxt_s = count_r;
    wrap_nxt_s  = {N_CH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      if (ch_load[i]) begin
        count_nxt_s[i] = load_value;
        wrap_nxt_s[i]  = 1'b0;
      end else if (tick_s && ch_down[i]) begin
        if (count_r[i] == {WIDTH{1'b0}}) begin
          count_nxt_s[i] = wrap_max;
          wrap_nxt_s[i]  = 1'b1;
        end else begin
          count_nxt_s[i] = count_r[i] - WIDTH'(1);
          wrap_nxt_s[i]  = 1'b0;
        end
      end else if (tick_s) begin
        // Only an exact match wraps, so an out-of-range count rolls over naturally at 2^WIDTH.
        if (count_r[i] == wrap_max) begin
          count_nxt_s[i] = {WIDTH{1'b0}};
          wrap_nxt_s[i]  = 1'b1;
        end else begin
          count_nxt_s[i] = count_r[i] + WIDTH'(1);
          wrap_nxt_s[i]  = 1'b0;
        end
      end else begin
        count_nxt_s[i] = count_r[i];
        wrap_nxt_s[i]  = 1'b0;
      end
    end
  end

  // Counter, wrap and tick registers update together so tick marks the cycle the new count shows.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {(N_CH*WIDTH){1'b0}};
      wrap_r  <= {N_CH{1'b0}};
      tick_r  <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      wrap_r  <= wrap_nxt_s;
      tick_r  <= tick_s;
    end
  end

  assign count = count_r;
  assign wrap  = wrap_r;
  assign tick  = tick_r;

`ifdef SNAPSHOT_EN
  logic [N_CH*WIDTH-1:0] snap_r;

  // Snapshot: captures the currently visible counts of all channels at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_r <= {(N_CH*WIDTH){1'b0}};
    end else if (snap_req) begin
      snap_r <= count_r;
    end else begin
      snap_r <= snap_r;
    end
  end

  assign snap_count = snap_r;
`endif

endmodule
